// File: rtl/sync_edge_filter_pkg.sv
// Shared definitions for the synchronised-input consumer stages.
package sync_edge_filter_pkg;

    // Edge-type encoding carried in the event register.
    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Defaults shared by every consumer of a two-flop synchroniser.
    localparam int DEF_FILT_LEN = 4;
    localparam int DEF_CNT_W    = 8;

    // Bits needed to hold values 0..v-1 (returns at least 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_filter_glitch.sv
// Consecutive-sample glitch filter: the level only changes after FILT_LEN
// samples in a row disagree with it. Also exposes the accept strobe one
// cycle early so the parent can update its state on the same edge.
module sync_glitch_filter
    import sync_edge_filter_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN,
    parameter bit INIT_LVL = 1'b0
) (
    input  logic clk_b,
    input  logic rst_b,
    input  logic sig_b,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o,
    output logic acc_o,
    output logic acc_edge_o
);

    localparam int CW = clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          acc;

    // Count differing samples; toggle and restart on the FILT_LEN-th one.
    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        acc   = 1'b0;
        if (sig_b == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            acc   = 1'b1;
            lvl_d = ~lvl_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = acc & ~lvl_q;
        fall_d = acc &  lvl_q;
    end

    // Level, stability counter and edge strobes.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            cnt_q  <= '0;
            lvl_q  <= INIT_LVL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign lvl_o      = lvl_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign acc_o      = acc;
    assign acc_edge_o = lvl_d;

endmodule

// File: rtl/sync_edge_filter.sv
// Filtered edge detector with a one-entry event register, sticky overrun
// and a saturating edge counter. Event state updates on the same edge that
// the filtered level changes, so evt_* line up with rise_p/fall_p.
module sync_edge_filter
    import sync_edge_filter_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN,
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit INIT_LVL = 1'b0
) (
    input  logic             clk_b,
    input  logic             rst_b,
    input  logic             sig_b,
    output logic             filt_lvl,
    output logic             rise_p,
    output logic             fall_p,
    output logic             evt_valid,
    output logic             evt_edge,
    input  logic             evt_ready,
    output logic             evt_overrun,
    output logic [CNT_W-1:0] evt_count,
    input  logic             clr_count
);

    logic             acc, acc_edge;
    logic             valid_q, valid_d;
    logic             edge_q, edge_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_glitch_filter #(
        .FILT_LEN (FILT_LEN),
        .INIT_LVL (INIT_LVL)
    ) u_filt (
        .clk_b      (clk_b),
        .rst_b      (rst_b),
        .sig_b      (sig_b),
        .lvl_o      (filt_lvl),
        .rise_o     (rise_p),
        .fall_o     (fall_p),
        .acc_o      (acc),
        .acc_edge_o (acc_edge)
    );

    // Event register, overrun and counter; clear applies before a new edge.
    always_comb begin
        valid_d = valid_q;
        edge_d  = edge_q;
        ovr_d   = clr_count ? 1'b0 : ovr_q;
        cnt_d   = clr_count ? '0 : cnt_q;
        if (acc) begin
            if (!valid_q || evt_ready) begin
                valid_d = 1'b1;
                edge_d  = acc_edge;
            end else begin
                ovr_d = 1'b1;
            end
            if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end
    end

    // Event-side state registers.
    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            valid_q <= 1'b0;
            edge_q  <= EDGE_FALL;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            edge_q  <= edge_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign evt_valid   = valid_q;
    assign evt_edge    = edge_q;
    assign evt_overrun = ovr_q;
    assign evt_count   = cnt_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Randomised bench for sync_edge_filter with a behavioural reference model.
// Two DUTs share the stimulus: CNT_W=8 and CNT_W=2 (saturation).
module tb_sync_edge_filter;

    localparam int FL = 4;

    logic       clk_b = 1'b0;
    logic       rst_b = 1'b1;
    logic       sig_b = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clr_count = 1'b0;

    logic       filt_lvl, rise_p, fall_p, evt_valid, evt_edge, evt_overrun;
    logic [7:0] evt_count;
    logic       f2_lvl, f2_rise, f2_fall, f2_valid, f2_edge, f2_ovr;
    logic [1:0] f2_count;

    int checks = 0;
    int errors = 0;

    always #5 clk_b = ~clk_b;

    sync_edge_filter #(.FILT_LEN(FL), .CNT_W(8), .INIT_LVL(1'b0)) dut (
        .clk_b(clk_b), .rst_b(rst_b), .sig_b(sig_b),
        .filt_lvl(filt_lvl), .rise_p(rise_p), .fall_p(fall_p),
        .evt_valid(evt_valid), .evt_edge(evt_edge), .evt_ready(evt_ready),
        .evt_overrun(evt_overrun), .evt_count(evt_count), .clr_count(clr_count)
    );

    sync_edge_filter #(.FILT_LEN(FL), .CNT_W(2), .INIT_LVL(1'b0)) dut2 (
        .clk_b(clk_b), .rst_b(rst_b), .sig_b(sig_b),
        .filt_lvl(f2_lvl), .rise_p(f2_rise), .fall_p(f2_fall),
        .evt_valid(f2_valid), .evt_edge(f2_edge), .evt_ready(evt_ready),
        .evt_overrun(f2_ovr), .evt_count(f2_count), .clr_count(clr_count)
    );

    // Reference model: level accepted after FL consecutive disagreeing samples.
    int m_lvl, m_run, m_rise, m_fall, m_valid, m_edge, m_ovr, m_c8, m_c2;
    bit armed = 1'b0;

    always @(posedge clk_b) begin
        int acc;
        if (rst_b) begin
            armed = 1'b1;
            m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0;
            m_valid = 0; m_edge = 0; m_ovr = 0; m_c8 = 0; m_c2 = 0;
        end else begin
            acc = 0;
            if (int'(sig_b) == m_lvl) m_run = 0;
            else begin
                m_run = m_run + 1;
                if (m_run == FL) begin acc = 1; m_run = 0; end
            end
            m_rise = 0; m_fall = 0;
            if (clr_count) begin m_c8 = 0; m_c2 = 0; m_ovr = 0; end
            if (acc) begin
                m_lvl = 1 - m_lvl;
                if (m_lvl == 1) m_rise = 1; else m_fall = 1;
                if (m_valid == 0 || evt_ready) begin m_valid = 1; m_edge = m_lvl; end
                else m_ovr = 1;
                if (m_c8 < 255) m_c8 = m_c8 + 1;
                if (m_c2 < 3) m_c2 = m_c2 + 1;
            end else if (m_valid == 1 && evt_ready) begin
                m_valid = 0;
            end
        end
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_b) begin
        if (armed) begin
            chk("filt_lvl", int'(filt_lvl), m_lvl);
            chk("rise_p", int'(rise_p), m_rise);
            chk("fall_p", int'(fall_p), m_fall);
            chk("evt_valid", int'(evt_valid), m_valid);
            if (m_valid == 1) chk("evt_edge", int'(evt_edge), m_edge);
            chk("evt_overrun", int'(evt_overrun), m_ovr);
            chk("evt_count", int'(evt_count), m_c8);
            chk("count_w2", int'(f2_count), m_c2);
            chk("w2_valid", int'(f2_valid), m_valid);
        end
    end

    // Drive one cycle of inputs, then wait to the next falling edge.
    task automatic tick(input bit s, input bit r, input bit c, input bit rs);
        sig_b = s; evt_ready = r; clr_count = c; rst_b = rs;
        @(negedge clk_b);
    endtask

    initial begin
        @(negedge clk_b);
        // Reset with sig_b low.
        repeat (20) tick(0, 0, 0, 1);
        chk("lit_rst_lvl", int'(filt_lvl), 0);
        chk("lit_rst_cnt", int'(evt_count), 0);
        chk("lit_rst_valid", int'(evt_valid), 0);

        // Reset after 2 of 4 differing samples: a full 4 needed afterwards.
        repeat (2) tick(1, 0, 0, 0);
        tick(1, 0, 0, 1);
        repeat (3) tick(1, 0, 0, 0);
        chk("lit_rst_partial", int'(rise_p), 0);
        tick(1, 0, 0, 0);
        chk("lit_rise_p", int'(rise_p), 1);
        chk("lit_rise_edge", int'(evt_edge), 1);
        chk("lit_rise_cnt", int'(evt_count), 1);
        tick(1, 0, 0, 0);
        chk("lit_rise_once", int'(rise_p), 0);

        // 3-cycle glitch is rejected; 4 low samples give a fall, overrun.
        repeat (3) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("lit_glitch_lvl", int'(filt_lvl), 1);
        repeat (4) tick(0, 0, 0, 0);
        chk("lit_fall_p", int'(fall_p), 1);
        chk("lit_ovr_edge", int'(evt_edge), 1);
        chk("lit_ovr", int'(evt_overrun), 1);
        chk("lit_ovr_cnt", int'(evt_count), 2);
        tick(0, 1, 0, 0);
        chk("lit_drain", int'(evt_valid), 0);
        chk("lit_ovr_sticky", int'(evt_overrun), 1);
        tick(0, 0, 1, 0);
        chk("lit_clr", int'(evt_overrun), 0);

        // Fall accepted in the same cycle a held rise is drained.
        repeat (4) tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("lit_swap_valid", int'(evt_valid), 1);
        chk("lit_swap_edge", int'(evt_edge), 0);
        chk("lit_swap_ovr", int'(evt_overrun), 0);

        // Saturation of the 2-bit counter, then clear coincident with an edge.
        repeat (4) tick(1, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        chk("lit_sat", int'(f2_count), 3);
        repeat (3) tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        chk("lit_clr_edge", int'(evt_count), 1);
        chk("lit_clr_edge_w2", int'(f2_count), 1);

        // Random runs of varying length against the model.
        for (int n = 0; n < 1500; n++) begin
            bit s;
            int len;
            s = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                tick(s, ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
                     ($urandom_range(0, 300) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
